// File: rtl/rf_pkg.sv
// Shared register-file writeback definitions: widths and writeback source encoding.
package rf_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 1 << REG_AW;

  typedef enum logic {
    WB_SRC_A = 1'b0,
    WB_SRC_B = 1'b1
  } wb_src_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for outstanding B writebacks: set/clear priority, decode stall
// compare and the sticky protocol-error flag.
module regfile_scoreboard #(
  parameter int unsigned REG_AW = rf_pkg::REG_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [REG_AW-1:0]        alloc_rd,
  input  logic                     clr_valid,
  input  logic [REG_AW-1:0]        clr_rd,
  input  logic                     a_fire,
  input  logic [REG_AW-1:0]        a_rd,
  input  logic                     b_fire,
  input  logic [REG_AW-1:0]        b_rd,
  input  logic [REG_AW-1:0]        rs1,
  input  logic [REG_AW-1:0]        rs2,
  output logic                     stall,
  output logic [(1<<REG_AW)-1:0]   busy_mask,
  output logic                     sb_err
);
  localparam int unsigned NREG = 1 << REG_AW;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            err_now;

  // Set is applied after clear so a same-edge alloc to a committing index wins.
  always_comb begin
    busy_next = busy;
    if (clr_valid) busy_next[clr_rd] = 1'b0;
    if (alloc_valid && alloc_rd != '0) busy_next[alloc_rd] = 1'b1;
    busy_next[0] = 1'b0;

    err_now = 1'b0;
    if (alloc_valid && alloc_rd != '0 && busy[alloc_rd] &&
        !(clr_valid && clr_rd == alloc_rd)) err_now = 1'b1;
    if (b_fire && b_rd != '0 && !busy[b_rd]) err_now = 1'b1;
    if (a_fire && a_rd != '0 && busy[a_rd]) err_now = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy <= busy_next;
      if (err_now) sb_err <= 1'b1;
    end
  end

  assign stall     = (rs1 != '0 && busy[rs1]) || (rs2 != '0 && busy[rs2]);
  assign busy_mask = busy;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the single-cycle A path and the
// multi-cycle B path, with a one-cycle registered write and a busy scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN   = rf_pkg::XLEN,
  parameter int unsigned REG_AW = rf_pkg::REG_AW,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [REG_AW-1:0]      a_rd,
  input  logic [XLEN-1:0]        a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [REG_AW-1:0]      b_rd,
  input  logic [XLEN-1:0]        b_data,
  input  logic                   alloc_valid,
  input  logic [REG_AW-1:0]      alloc_rd,
  input  logic [REG_AW-1:0]      rs1,
  input  logic [REG_AW-1:0]      rs2,
  output logic                   stall,
  output logic                   RegWrite,
  output logic [REG_AW-1:0]      wr_rd,
  output logic [XLEN-1:0]        write_data,
  output logic [(1<<REG_AW)-1:0] busy_mask,
  output logic                   sb_err
);
  import rf_pkg::*;

  logic    grant_a;
  logic    grant_b;
  wb_src_e last_grant;
  wb_src_e out_src;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        if (RR_EN && last_grant == WB_SRC_A) grant_b = 1'b1;
        else                                 grant_a = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Writes to x0 are accepted and update last_grant but never raise RegWrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      wr_rd      <= '0;
      write_data <= '0;
      out_src    <= WB_SRC_A;
      last_grant <= WB_SRC_B;
    end else if (grant_a) begin
      RegWrite   <= (a_rd != '0);
      wr_rd      <= a_rd;
      write_data <= a_data;
      out_src    <= WB_SRC_A;
      last_grant <= WB_SRC_A;
    end else if (grant_b) begin
      RegWrite   <= (b_rd != '0);
      wr_rd      <= b_rd;
      write_data <= b_data;
      out_src    <= WB_SRC_B;
      last_grant <= WB_SRC_B;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  regfile_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .clr_valid   (RegWrite && out_src == WB_SRC_B),
    .clr_rd      (wr_rd),
    .a_fire      (grant_a),
    .a_rd        (a_rd),
    .b_fire      (grant_b),
    .b_rd        (b_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .stall       (stall),
    .busy_mask   (busy_mask),
    .sb_err      (sb_err)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed steps plus a randomized phase checked against an array/queue model
// of the writeback and scoreboard rules.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int XL = 32;
  localparam int NR = 32;

  logic          clk;
  logic          rst;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_rd, b_rd, alloc_rd, rs1, rs2, wr_rd;
  logic [XL-1:0] a_data, b_data, write_data;
  logic          alloc_valid, stall, RegWrite, sb_err;
  logic [NR-1:0] busy_mask;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.XLEN(XL), .REG_AW(AW), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .RegWrite(RegWrite), .wr_rd(wr_rd), .write_data(write_data),
    .busy_mask(busy_mask), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; alloc_valid = 0;
    a_rd = '0; b_rd = '0; alloc_rd = '0; a_data = '0; b_data = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  // Reference model state
  bit            m_busy [NR];
  bit            m_err;
  bit            m_last_b;
  bit            e_rw, e_src_b;
  logic [AW-1:0] e_wr_rd;
  logic [XL-1:0] e_wd;
  logic [AW-1:0] bq[$];

  function automatic logic [NR-1:0] model_mask();
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) m[i] = m_busy[i];
    return m;
  endfunction

  function automatic logic [AW-1:0] pick_free();
    logic [AW-1:0] r;
    for (int t = 0; t < 4; t++) begin
      r = AW'($urandom);
      if (!m_busy[r]) return r;
    end
    return '0;
  endfunction

  initial begin
    bit            m_ga, m_gb, fa, fb, last_fa, last_fb, clr, exp_stall;
    bit            pre [NR];
    logic [AW-1:0] r;

    idle_inputs();
    rst = 1;
    a_valid = 1; b_valid = 1;
    #12;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wr_rd", wr_rd, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_sb_err", sb_err, 0);
    @(negedge clk); a_valid = 0; b_valid = 0; rst = 0;

    // Single A write
    @(negedge clk); a_valid = 1; a_rd = 5; a_data = 32'h0000_00AA;
    #1 chk("a1_ready", a_ready, 1);
    chk("a1_b_ready", b_ready, 0);
    @(posedge clk); #1 a_valid = 0;
    chk("a1_regwrite", RegWrite, 1);
    chk("a1_wr_rd", wr_rd, 5);
    chk("a1_wdata", write_data, 32'hAA);
    @(posedge clk); #1
    chk("a1_regwrite_off", RegWrite, 0);
    chk("a1_wr_rd_hold", wr_rd, 5);

    // Contention after reset; rd=2 kept busy through a same-edge re-alloc
    do_reset();
    alloc_valid = 1; alloc_rd = 2;
    @(negedge clk); alloc_valid = 0;
    a_valid = 1; a_rd = 1; a_data = 32'h11;
    b_valid = 1; b_rd = 2; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      alloc_valid = (i == 2); alloc_rd = 2;
      #1 chk("rr_a_ready", a_ready, (i % 2 == 0));
      chk("rr_b_ready", b_ready, (i % 2 == 1));
      @(posedge clk); #1
      chk("rr_regwrite", RegWrite, 1);
      chk("rr_wr_rd", wr_rd, (i % 2 == 0) ? 1 : 2);
    end
    @(negedge clk); a_valid = 0; b_valid = 0; alloc_valid = 0;
    chk("rr_sb_err", sb_err, 0);
    chk("rr_busy2", busy_mask[2], 1);
    @(posedge clk); #1 chk("rr_busy_clear", busy_mask, 0);

    // Scoreboard stall on rd=7
    @(negedge clk); alloc_valid = 1; alloc_rd = 7; rs1 = 7;
    @(posedge clk); #1 chk("sb_stall_set", stall, 1);
    @(negedge clk); alloc_valid = 0; b_valid = 1; b_rd = 7; b_data = 32'h1234;
    #1 chk("sb_b_ready", b_ready, 1);
    chk("sb_stall_hold", stall, 1);
    @(posedge clk); #1 b_valid = 0;
    chk("sb_regwrite", RegWrite, 1);
    chk("sb_wr_rd", wr_rd, 7);
    chk("sb_wdata", write_data, 32'h1234);
    chk("sb_stall_port", stall, 1);
    @(posedge clk); #1
    chk("sb_stall_clear", stall, 0);
    chk("sb_busy7", busy_mask[7], 0);
    rs1 = 0;

    // x0 then non-busy B write
    @(negedge clk); b_valid = 1; b_rd = 0; b_data = 32'h55;
    #1 chk("x0_b_ready", b_ready, 1);
    @(posedge clk); #1 b_valid = 0;
    chk("x0_regwrite", RegWrite, 0);
    chk("x0_sb_err", sb_err, 0);
    @(negedge clk); b_valid = 1; b_rd = 3; b_data = 32'h66;
    @(posedge clk); #1 b_valid = 0;
    chk("err_b_nonbusy", sb_err, 1);
    @(posedge clk); #1 chk("err_sticky", sb_err, 1);

    // Same-edge alloc and commit on rd=9
    do_reset();
    alloc_valid = 1; alloc_rd = 9;
    @(negedge clk); alloc_valid = 0; b_valid = 1; b_rd = 9; b_data = 32'h99;
    @(posedge clk); #1 b_valid = 0;
    @(negedge clk); alloc_valid = 1; alloc_rd = 9;
    @(posedge clk); #1 alloc_valid = 0;
    chk("same_edge_busy9", busy_mask[9], 1);
    chk("same_edge_sb_err", sb_err, 0);

    // Async reset in the middle of a write cycle
    do_reset();
    alloc_valid = 1; alloc_rd = 4; a_valid = 1; a_rd = 6; a_data = 32'hBEEF;
    @(posedge clk); #1 a_valid = 0; alloc_valid = 0;
    chk("ar_regwrite_pre", RegWrite, 1);
    chk("ar_busy_pre", busy_mask, 32'h10);
    #2 rst = 1;
    #1 chk("ar_regwrite", RegWrite, 0);
    chk("ar_busy", busy_mask, 0);
    chk("ar_wr_rd", wr_rd, 0);
    @(negedge clk); rst = 0;

    // Randomized phase against the model
    do_reset();
    for (int i = 0; i < NR; i++) m_busy[i] = 0;
    m_err = 0; m_last_b = 1; e_rw = 0; e_src_b = 0; e_wr_rd = '0; e_wd = '0;
    last_fa = 0; last_fb = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!a_valid || last_fa) begin
        a_valid = 1'($urandom_range(0, 1));
        a_rd = pick_free();
        a_data = $urandom;
      end
      if (!b_valid || last_fb) begin
        b_valid = 0;
        if (bq.size() > 0 && $urandom_range(0, 1) == 1) begin
          b_valid = 1; b_rd = bq.pop_front(); b_data = $urandom;
        end
      end
      alloc_valid = 0;
      if ($urandom_range(0, 3) == 0) begin
        r = AW'($urandom_range(1, NR - 1));
        if (!m_busy[r] && !(a_valid && a_rd == r)) begin
          alloc_valid = 1; alloc_rd = r; bq.push_back(r);
        end
      end
      rs1 = AW'($urandom); rs2 = AW'($urandom);
      #1;
      if (a_valid && b_valid) begin
        m_gb = !m_last_b; m_ga = m_last_b;
      end else begin
        m_ga = a_valid; m_gb = b_valid;
      end
      exp_stall = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]);
      chk("rnd_a_ready", a_ready, m_ga);
      chk("rnd_b_ready", b_ready, m_gb);
      chk("rnd_stall", stall, exp_stall);

      @(posedge clk);
      fa = m_ga; fb = m_gb;
      pre = m_busy;
      clr = e_rw && e_src_b;
      if (alloc_valid && alloc_rd != 0 && pre[alloc_rd] && !(clr && e_wr_rd == alloc_rd)) m_err = 1;
      if (fb && b_rd != 0 && !pre[b_rd]) m_err = 1;
      if (fa && a_rd != 0 && pre[a_rd]) m_err = 1;
      if (clr) m_busy[e_wr_rd] = 0;
      if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1;
      if (fa) begin
        e_rw = (a_rd != 0); e_wr_rd = a_rd; e_wd = a_data; e_src_b = 0; m_last_b = 0;
      end else if (fb) begin
        e_rw = (b_rd != 0); e_wr_rd = b_rd; e_wd = b_data; e_src_b = 1; m_last_b = 1;
      end else begin
        e_rw = 0;
      end
      last_fa = fa; last_fb = fb;
      #1;
      chk("rnd_regwrite", RegWrite, e_rw);
      chk("rnd_wr_rd", wr_rd, e_wr_rd);
      chk("rnd_wdata", write_data, e_wd);
      chk("rnd_busy", busy_mask, model_mask());
      chk("rnd_sb_err", sb_err, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (RegWrite / rd / write_data) between two writeback requesters. Requester A is the single-cycle ALU/immediate path; requester B is the multi-cycle load/MMIO path.
- Keeps a per-register busy scoreboard for outstanding B writebacks and raises a decode-stage stall when rs1/rs2 hit a pending destination.
- Sits between the execute/memory stages and the register file's write inputs.

Parameters:
- XLEN, 32, data width of write_data and requester payloads
- REG_AW, 5, register index width (2**REG_AW registers)
- RR_EN, 1, 1 = round-robin between A and B on conflict; 0 = fixed priority to A

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  A writeback request
- a_ready  out  1  A request accepted this cycle (when a_valid)
- a_rd  in  REG_AW  A destination register
- a_data  in  XLEN  A write value
- b_valid  in  1  B writeback request
- b_ready  out  1  B request accepted this cycle (when b_valid)
- b_rd  in  REG_AW  B destination register
- b_data  in  XLEN  B write value
- alloc_valid  in  1  issue stage launched a B-type op
- alloc_rd  in  REG_AW  destination of that op
- rs1  in  REG_AW  decode-stage source 1
- rs2  in  REG_AW  decode-stage source 2
- stall  out  1  rs1/rs2 matches a busy register
- RegWrite  out  1  register file write enable
- wr_rd  out  REG_AW  register file write index
- write_data  out  XLEN  register file write value
- busy_mask  out  2**REG_AW  scoreboard bits; bit 0 always 0
- sb_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, immediate): RegWrite=0, wr_rd=0, write_data=0, busy_mask=0, sb_err=0, last_grant=B (so A wins the first tie). a_ready and b_ready are 0 while rst is high.
- Arbitration (combinational, every cycle):
  - Only one valid: that requester is granted.
  - Both valid, RR_EN=1: grant the requester not in last_grant.
  - Both valid, RR_EN=0: grant A.
  - a_ready = grant_a; b_ready = grant_b; at most one ready per cycle.
  - last_grant updates only on an accepted transfer.
- Handshake: a transfer happens when valid && ready at a rising edge. The requester holds valid and stable payload until accepted. Ready may depend on the other requester's valid. No combinational path from ready to valid is allowed inside requesters.
- Latency: one cycle. A transfer accepted at edge E drives RegWrite=1, wr_rd, write_data during the following cycle, and the register file captures at edge E+1. With no transfer, RegWrite=0 next cycle; wr_rd and write_data hold their previous values.
- rd=0: the transfer is accepted, RegWrite stays 0 and the scoreboard is unchanged.
- Back-to-back: a transfer may be accepted every cycle; the output register reloads each edge.
- Scoreboard:
  - alloc_valid with alloc_rd≠0 sets busy[alloc_rd] at the edge.
  - A registered B write (RegWrite && source=B) clears busy[wr_rd] at the same edge the register file captures, so decode reads the new value the next cycle.
  - Same-edge set and clear of one index: set wins.
- stall = (rs1≠0 && busy[rs1]) || (rs2≠0 && busy[rs2]), combinational.
- sb_err is set and held until reset when any of these occur:
  - alloc to an already-busy register with no same-edge clear;
  - B transfer accepted for a non-busy rd≠0;
  - A transfer accepted for a busy rd (WAW against pending load). The A write still occurs and the busy bit is unchanged.
- Reset mid-transfer: the in-flight output write is dropped (RegWrite forced 0) and all busy bits are cleared.

Decomposition:
- Shared package (rf_pkg): XLEN, REG_AW, NREG, and enum wb_src_e {WB_SRC_A, WB_SRC_B}, also used by the writeback mux elsewhere.
- One sub-module: regfile_scoreboard. It holds the busy vector, set/clear/priority rules, the stall compare and sb_err. The arbiter keeps grant logic, last_grant and the output register.

Test Plan:
- Single A: a_valid=1, a_rd=5, a_data=0x0000_00AA → a_ready=1 same cycle; next cycle RegWrite=1, wr_rd=5, write_data=0xAA; following cycle RegWrite=0.
- Contention, RR_EN=1, both held valid for 4 cycles after reset (A rd=1, B rd=2) → grants A,B,A,B; wr_rd sequence 1,2,1,2, one per cycle.
- Scoreboard: alloc rd=7; rs1=7 → stall=1 until the B write to rd=7 (0x1234) appears on the port; stall=0 the cycle after; busy_mask[7]=0.
- x0 and errors: B transfer with rd=0 → no RegWrite, sb_err=0; then B transfer to non-busy rd=3 → sb_err=1 and held.
- Same-edge alloc rd=9 with B commit to rd=9 → busy_mask[9]=1 afterwards, sb_err=0.
- Async reset asserted mid-cycle after accept → RegWrite=0 and busy_mask=0 immediately, before the next clock edge.
